vector_collector: RTL and testbench

- Producer-side counterpart of the vector adder-tree accumulator.
- Receives fixed-point `data` words serially over a valid/ready stream and packs them into one `ARR` vector of `MAX_NEURONS` elements.
- Presents that vector, zero-padded and held stable, on an output valid/ready handshake, so that adder-tree consumers (e.g. `accumulator`) see complete vectors only.
- Sits between the serial weight/activation fetch path and the parallel neuron datapath.

---
 rtl/vector_collector.sv | 95 +++++++++
 tb/tb_vector_collector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vector_collector.sv
// Packs serial valid/ready words into one zero-padded vector; vec_valid rises the cycle after the closing word.
// in_ready drops while a vector is held, and the held vector stays stable until vec_ready.
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

module vector_collector #(
  parameter int MAX_NEURONS = `MAX_NEURONS,
  parameter int DATA_W      = 16,
  parameter int COUNT_W     = $clog2(MAX_NEURONS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_W-1:0]                   in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [MAX_NEURONS-1:0][DATA_W-1:0]  vec_out,
  output logic [COUNT_W-1:0]                  vec_count,
  output logic                                vec_valid,
  input  logic                                vec_ready,
  output logic                                vec_nolast
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                               state_q, state_d;
  logic [COUNT_W-1:0]                   idx_q, idx_d;
  logic [MAX_NEURONS-1:0][DATA_W-1:0]   vec_q, vec_d;
  logic [COUNT_W-1:0]                   count_q, count_d;
  logic                                 valid_q, valid_d;
  logic                                 nolast_q, nolast_d;

  assign in_ready   = (state_q == FILL) && !rst;
  assign vec_out    = vec_q;
  assign vec_count  = count_q;
  assign vec_valid  = valid_q;
  assign vec_nolast = nolast_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vec_d    = vec_q;
    count_d  = count_q;
    valid_d  = valid_q;
    nolast_d = nolast_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int i = 0; i < MAX_NEURONS; i++) begin
            if (idx_q == COUNT_W'(i)) vec_d[i] = in_data;
          end
          idx_d = idx_q + COUNT_W'(1);
          if (in_last || idx_q == COUNT_W'(MAX_NEURONS - 1)) begin
            // idx parks at 0 on close so it can never point into the held vector
            state_d  = HOLD;
            idx_d    = '0;
            valid_d  = 1'b1;
            count_d  = idx_q + COUNT_W'(1);
            nolast_d = !in_last;
          end
        end
      end
      HOLD: begin
        if (valid_q && vec_ready) begin
          state_d  = FILL;
          idx_d    = '0;
          vec_d    = '0;
          valid_d  = 1'b0;
          nolast_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      idx_q    <= '0;
      vec_q    <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      nolast_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vec_q    <= vec_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      nolast_q <= nolast_d;
    end
  end

endmodule

// File: tb/tb_vector_collector.sv
// Bench for vector_collector: directed scenarios plus randomized handshakes against a queue-based model.
module tb_vector_collector;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = $clog2(N + 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [W-1:0]          in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [N-1:0][W-1:0]   vec_out;
  logic [CW-1:0]         vec_count;
  logic                  vec_valid;
  logic                  vec_ready;
  logic                  vec_nolast;

  vector_collector #(.MAX_NEURONS(N), .DATA_W(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .vec_out(vec_out), .vec_count(vec_count), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_nolast(vec_nolast)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: words of the vector being built or held, plus the registered side info
  logic [W-1:0] elems[$];
  bit           holding;
  int           m_count;
  bit           m_nolast;

  logic [W-1:0] src_q[$];
  logic [W-1:0] emit_q[$];
  bit           last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] padded();
    logic [N*W-1:0] v = '0;
    for (int i = 0; i < elems.size(); i++) v[i*W +: W] = elems[i];
    return v;
  endfunction

  task automatic model_step();
    if (rst) begin
      elems.delete(); holding = 0; m_count = 0; m_nolast = 0;
    end else if (!holding) begin
      if (in_valid) begin
        elems.push_back(in_data);
        if (in_last || elems.size() == N) begin
          holding = 1; m_count = elems.size(); m_nolast = !in_last;
        end
      end
    end else if (vec_ready) begin
      holding = 0; elems.delete(); m_nolast = 0;
    end
  endtask

  task automatic tick();
    #1;
    last_acc = !rst && in_valid && in_ready;
    if (last_acc) src_q.push_back(in_data);
    if (!rst && vec_valid && vec_ready)
      for (int i = 0; i < int'(vec_count); i++) emit_q.push_back(vec_out[i]);
    model_step();
    @(posedge clk);
    #1;
    chk("in_ready", in_ready, !holding && !rst);
    chk("vec_valid", vec_valid, holding);
    chk("vec_out", vec_out, padded());
    chk("vec_count", vec_count, m_count);
    chk("vec_nolast", vec_nolast, m_nolast);
  endtask

  task automatic send(input logic [W-1:0] d, input logic l);
    in_valid = 1; in_data = d; in_last = l;
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic handshake();
    vec_ready = 1; tick(); vec_ready = 0;
  endtask

  initial begin
    int sum;
    int n_src;
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; vec_ready = 0;
    elems.delete(); holding = 0; m_count = 0; m_nolast = 0;
    tick(); tick();
    rst = 0;
    tick();
    chk("reset in_ready", in_ready, 1);
    chk("reset vec_valid", vec_valid, 0);
    chk("reset vec_out", vec_out, 64'h0);
    chk("reset vec_count", vec_count, 0);
    chk("reset vec_nolast", vec_nolast, 0);

    // full vector, closed by in_last on the last element
    send(5, 0); send(7, 0); send(9, 0);
    chk("full not yet valid", vec_valid, 0);
    send(11, 1);
    chk("full vec_valid", vec_valid, 1);
    chk("full vec_out", vec_out, 64'h000b_0009_0007_0005);
    chk("full vec_count", vec_count, 4);
    chk("full vec_nolast", vec_nolast, 0);
    tick();
    chk("full held in_ready", in_ready, 0);
    chk("full held vec_out", vec_out, 64'h000b_0009_0007_0005);
    handshake();
    chk("full post hs vec_valid", vec_valid, 0);
    chk("full post hs in_ready", in_ready, 1);
    chk("full post hs vec_out", vec_out, 64'h0);

    // short vector and its accumulated sum
    send(3, 0); send(4, 1);
    chk("short vec_out", vec_out, 64'h0000_0000_0004_0003);
    chk("short vec_count", vec_count, 2);
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(vec_out[i]);
    chk("short sum", sum, 7);
    handshake();

    // missing last: closes on full, next word opens a new vector
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    chk("nolast vec_out", vec_out, 64'h0004_0003_0002_0001);
    chk("nolast flag", vec_nolast, 1);
    handshake();
    send(8, 1);
    chk("after nolast vec_out", vec_out, 64'h0000_0000_0000_0008);
    chk("after nolast count", vec_count, 1);
    chk("after nolast flag", vec_nolast, 0);
    handshake();

    // backpressure: word 6 waits through HOLD and is consumed once
    send(1, 1);
    n_src = src_q.size();
    in_valid = 1; in_data = 6; in_last = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp not consumed", src_q.size() - n_src, 0);
    handshake();
    tick();
    in_valid = 0;
    chk("bp consumed once", src_q.size() - n_src, 1);
    chk("bp element 0", vec_out, 64'h0000_0000_0000_0006);
    tick();
    chk("bp no dup", src_q.size() - n_src, 1);
    send(2, 1);
    chk("bp vec_out", vec_out, 64'h0000_0000_0002_0006);
    handshake();

    // reset mid-vector discards the partial vector
    send(1, 0); send(2, 0);
    rst = 1; tick(); rst = 0;
    tick();
    chk("midrst in_ready", in_ready, 1);
    chk("midrst vec_out", vec_out, 64'h0);
    chk("midrst vec_count", vec_count, 0);
    send(9, 1);
    chk("midrst next vec_out", vec_out, 64'h0000_0000_0000_0009);
    chk("midrst next count", vec_count, 1);
    handshake();

    // randomized traffic; an offered word is held until accepted
    src_q.delete(); emit_q.delete();
    last_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = W'($urandom);
        in_last  = ($urandom_range(0, 3) == 0);
      end
      vec_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    in_valid = 0; in_last = 0; vec_ready = 1;
    for (int c = 0; c < 4; c++) tick();
    vec_ready = 0;
    chk("rand emit not empty", emit_q.size() > 100, 1);
    chk("rand leftover bound", (src_q.size() >= emit_q.size()) && (src_q.size() - emit_q.size() < N), 1);
    for (int i = 0; i < emit_q.size() && i < src_q.size(); i++)
      if (emit_q[i] !== src_q[i]) chk($sformatf("rand order %0d", i), emit_q[i], src_q[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
